regfile_wb_arbiter: RTL and testbench

- Writer-side front end for the CPU's register file, which has two read ports and one negedge write port.
- Merges two writeback sources into the single write port: the in-order pipeline WB stage and the multicycle mul/div unit (MDU).
- Buffers MDU results in a small FIFO and drives registered write/address/data to the register file.
- Reports pending destinations to the hazard logic so that stale registers are not read.

---
 rtl/regfile_wb_pkg.sv | 14 +
 rtl/wb_result_fifo.sv | 67 ++++++
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared widths, constants and payload type for the register-file writeback front end.
package regfile_wb_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;

   localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// MDU result buffer: synchronous FIFO with occupancy count and per-entry destination match.
module wb_result_fifo
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter type entry_t        = wb_req_t,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  entry_t            push_entry,
   input  logic              pop,
   output entry_t            head,
   output logic [CNT_W-1:0]  count,
   input  logic [ADDR_W-1:0] match_rd_a,
   input  logic [ADDR_W-1:0] match_rd_b,
   output logic [DEPTH-1:0]  match_a,
   output logic [DEPTH-1:0]  match_b
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   entry_t             mem [DEPTH];
   logic [DEPTH-1:0]   occupied;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;

   // Caller never pushes when full nor pops when empty, so push/pop slots never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         occupied <= '0;
      end else begin
         if (push) begin
            wr_ptr           <= wr_ptr + 1'b1;
            occupied[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr           <= rd_ptr + 1'b1;
            occupied[rd_ptr] <= 1'b0;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      match_a = '0;
      match_b = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         match_a[i] = occupied[i] && (mem[i].rd == match_rd_a);
         match_b[i] = occupied[i] && (mem[i].rd == match_rd_b);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline WB and buffered MDU results onto the single register-file write port.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DATA_W       = RF_DATA_W,
   parameter int unsigned ADDR_W       = RF_ADDR_W,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8,
   localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] mdu_rd,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              rs1_pending,
   output logic              rs2_pending,
   output logic              stall_wb,
   output logic [CNT_W-1:0]  fifo_count
);

   localparam int unsigned STV_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } req_t;

   req_t                  fifo_in;
   req_t                  fifo_head;
   req_t                  sel;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_busy;
   logic                  wb_take;
   logic                  sel_valid;
   logic                  starved;
   logic [FIFO_DEPTH-1:0] match_a;
   logic [FIFO_DEPTH-1:0] match_b;
   logic [STV_W-1:0]      starve_cnt;

   wb_result_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .ADDR_W  (ADDR_W),
      .entry_t (req_t)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push),
      .push_entry (fifo_in),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .count      (fifo_count),
      .match_rd_a (rs1),
      .match_rd_b (rs2),
      .match_a    (match_a),
      .match_b    (match_b)
   );

   // Pipeline has priority; the FIFO head drains only on idle pipeline cycles.
   always_comb begin
      mdu_ready    = fifo_count < CNT_W'(FIFO_DEPTH);
      fifo_busy    = fifo_count != '0;
      wb_take      = wb_valid && (wb_rd != ADDR_W'(REG_ZERO));
      fifo_pop     = !wb_take && fifo_busy;
      fifo_push    = mdu_valid && mdu_ready && (mdu_rd != ADDR_W'(REG_ZERO));
      fifo_in.rd   = mdu_rd;
      fifo_in.data = mdu_data;
      sel_valid    = wb_take || fifo_pop;
      sel          = fifo_head;
      if (wb_take) begin
         sel.rd   = wb_rd;
         sel.data = wb_data;
      end
      starved      = wb_take && fifo_busy;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_write <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_write <= sel_valid;
         if (sel_valid) begin
            rf_waddr <= sel.rd;
            rf_wdata <= sel.data;
         end
      end
   end

   // Counts consecutive blocked cycles of a waiting head; on the limit, request one bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         stall_wb   <= 1'b0;
      end else if (starved) begin
         if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) begin
            starve_cnt <= '0;
            stall_wb   <= 1'b1;
         end else begin
            starve_cnt <= starve_cnt + 1'b1;
            stall_wb   <= 1'b0;
         end
      end else begin
         starve_cnt <= '0;
         stall_wb   <= 1'b0;
      end
   end

   always_comb begin
      rs1_pending = (rs1 != ADDR_W'(REG_ZERO)) && ((|match_a) || (rf_write && (rf_waddr == rs1)));
      rs2_pending = (rs2 != ADDR_W'(REG_ZERO)) && ((|match_b) || (rf_write && (rf_waddr == rs2)));
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;
   localparam int SL    = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_valid;
   logic [AW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic          mdu_valid;
   logic          mdu_ready;
   logic [AW-1:0] mdu_rd;
   logic [DW-1:0] mdu_data;
   logic          rf_write;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic          rs1_pending;
   logic          rs2_pending;
   logic          stall_wb;
   logic [2:0]    fifo_count;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .DATA_W       (DW),
      .ADDR_W       (AW),
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .mdu_valid   (mdu_valid),
      .mdu_ready   (mdu_ready),
      .mdu_rd      (mdu_rd),
      .mdu_data    (mdu_data),
      .rf_write    (rf_write),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .rs1         (rs1),
      .rs2         (rs2),
      .rs1_pending (rs1_pending),
      .rs2_pending (rs2_pending),
      .stall_wb    (stall_wb),
      .fifo_count  (fifo_count)
   );

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   int            checks = 0;
   int            errors = 0;
   ent_t          q[$];
   logic          m_write;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   int            m_run;
   logic          m_stall;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic m_pend(input logic [AW-1:0] rs);
      if (rs == '0) return 1'b0;
      if (m_write && m_waddr == rs) return 1'b1;
      foreach (q[i]) if (q[i].rd == rs) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      q.delete();
      m_write = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_run   = 0;
      m_stall = 1'b0;
   endtask

   task automatic drive(input logic wv, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                        input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      wb_valid  = wv;
      wb_rd     = wr;
      wb_data   = wd;
      mdu_valid = mv;
      mdu_rd    = mr;
      mdu_data  = md;
      rs1       = r1;
      rs2       = r2;
   endtask

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic cycle();
      logic ready;
      logic take;
      logic busy;
      ent_t e;
      #1;
      ready = q.size() < DEPTH;
      chk("mdu_ready", 64'(mdu_ready), 64'(ready));
      chk("rs1_pending", 64'(rs1_pending), 64'(m_pend(rs1)));
      chk("rs2_pending", 64'(rs2_pending), 64'(m_pend(rs2)));
      take = wb_valid && wb_rd != '0;
      busy = q.size() != 0;
      if (take) begin
         m_write = 1'b1;
         m_waddr = wb_rd;
         m_wdata = wb_data;
      end else if (busy) begin
         e       = q.pop_front();
         m_write = 1'b1;
         m_waddr = e.rd;
         m_wdata = e.data;
      end else begin
         m_write = 1'b0;
      end
      if (take && busy) begin
         m_run++;
         m_stall = (m_run == SL);
         if (m_stall) m_run = 0;
      end else begin
         m_run   = 0;
         m_stall = 1'b0;
      end
      if (mdu_valid && ready && mdu_rd != '0) begin
         e.rd   = mdu_rd;
         e.data = mdu_data;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("rf_write", 64'(rf_write), 64'(m_write));
      chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      chk("fifo_count", 64'(fifo_count), 64'(q.size()));
      chk("stall_wb", 64'(stall_wb), 64'(m_stall));
   endtask

   initial begin
      logic [AW-1:0] r;
      int            pushed;
      int            guard;

      // Reset state
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_write", 64'(rf_write), 64'(0));
      chk("rst_waddr", 64'(rf_waddr), 64'(0));
      chk("rst_wdata", 64'(rf_wdata), 64'(0));
      chk("rst_count", 64'(fifo_count), 64'(0));
      chk("rst_stall", 64'(stall_wb), 64'(0));
      rst = 1'b0;
      #1;
      chk("rst_ready", 64'(mdu_ready), 64'(1));

      // Pipeline only
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
      cycle();
      chk("pipe_wdata", 64'(rf_wdata), 64'(32'hDEADBEEF));
      drive(1, 0, 32'h11111111, 0, 0, 0, 0, 0);
      cycle();
      chk("pipe_rd0", 64'(rf_write), 64'(0));

      // MDU only, pending window N+1..N+2
      drive(0, 0, 0, 1, 7, 32'h12345678, 7, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 7, 0);
      cycle();
      chk("mdu_waddr", 64'(rf_waddr), 64'(7));
      cycle();
      cycle();

      // Full FIFO behind a busy pipeline, then in-order drain
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'(1 + i), $urandom, 1, 5'(10 + i), 32'hA000_0000 + i, 5'(10 + i), 12);
         cycle();
      end
      chk("full_count", 64'(fifo_count), 64'(4));
      drive(1, 2, $urandom, 1, 20, 32'hBAD0BAD0, 20, 13);
      cycle();
      chk("full_ready", 64'(mdu_ready), 64'(0));
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 10, 13);
         cycle();
         chk("drain_order", 64'(rf_waddr), 64'(10 + i));
      end
      cycle();

      // Starvation: one buffered entry, pipeline busy until the bubble request
      drive(1, 3, 32'h3, 1, 9, 32'h99, 9, 0);
      cycle();
      for (int k = 1; k <= SL; k++) begin
         drive(1, 3, 32'h30 + k, 0, 0, 0, 9, 0);
         cycle();
         chk("starve_pulse", 64'(stall_wb), 64'(k == SL));
      end
      drive(0, 0, 0, 0, 0, 0, 9, 0);
      cycle();
      chk("starve_head", 64'(rf_waddr), 64'(9));
      chk("starve_stall_clr", 64'(stall_wb), 64'(0));
      cycle();

      // Concurrent sources
      drive(1, 3, 32'h33, 1, 4, 32'h44, 0, 4);
      cycle();
      chk("conc_first", 64'(rf_waddr), 64'(3));
      drive(0, 0, 0, 0, 0, 0, 3, 4);
      cycle();
      chk("conc_second", 64'(rf_waddr), 64'(4));
      cycle();

      // Randomized traffic, small index range to exercise matches
      for (int n = 0; n < 600; n++) begin
         r = 5'($urandom_range(0, 7));
         drive(!m_stall && ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 99) < 60, r, $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         cycle();
      end

      // Mid-run reset with three entries buffered
      pushed = 0;
      guard  = 0;
      while (pushed < 3 && guard < 50) begin
         drive(1, 6, $urandom, 1, 5'(20 + pushed), $urandom, 21, 0);
         if (mdu_ready && !m_stall) pushed++;
         if (m_stall) wb_valid = 1'b0;
         cycle();
         guard++;
      end
      chk("pre_rst_count", 64'(fifo_count), 64'(q.size()));
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("midrst_write", 64'(rf_write), 64'(0));
      chk("midrst_count", 64'(fifo_count), 64'(0));
      drive(0, 0, 0, 0, 0, 0, 21, 22);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_ready", 64'(mdu_ready), 64'(1));
      for (int i = 0; i < 4; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
